// File: rtl/core_pkg.sv
// Shared reorder-buffer types and sizing for the core.
package core_pkg;

   localparam int ROB_ENTRIES   = 32;
   localparam int ROB_IDX_WIDTH = $clog2(ROB_ENTRIES);

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  dst_reg;
      logic [6:0]  dst_preg;
      logic [6:0]  prev_preg;
      logic        has_dst;
   } ROB_Entry;

endpackage

// File: rtl/rob_if.sv
// Dispatch / writeback / retire bundle between the pipeline and the reorder buffer.
interface rob_if
   import core_pkg::*;
#(
   parameter int ENTRIES      = ROB_ENTRIES,
   parameter int DISP_WIDTH   = 2,
   parameter int NUM_FUS      = 4,
   parameter int RETIRE_WIDTH = 2
);
   localparam int IDX_W = $clog2(ENTRIES);

   logic [DISP_WIDTH-1:0]              alloc_valid;
   ROB_Entry [DISP_WIDTH-1:0]          alloc_entry;
   logic                               alloc_ready;
   logic [DISP_WIDTH-1:0][IDX_W-1:0]   alloc_idx;
   logic [NUM_FUS-1:0]                 wb_valid;
   logic [NUM_FUS-1:0][IDX_W-1:0]      wb_idx;
   logic [NUM_FUS-1:0]                 wb_exc;
   logic [RETIRE_WIDTH-1:0]            retire_valid;
   ROB_Entry [RETIRE_WIDTH-1:0]        retire_entry;
   logic                               flush_out;
   logic [31:0]                        flush_pc;
   logic                               rob_empty;
   logic [IDX_W:0]                     rob_count;

   modport master (
      output alloc_valid, alloc_entry, wb_valid, wb_idx, wb_exc,
      input  alloc_ready, alloc_idx, retire_valid, retire_entry,
             flush_out, flush_pc, rob_empty, rob_count
   );

   modport slave (
      input  alloc_valid, alloc_entry, wb_valid, wb_idx, wb_exc,
      output alloc_ready, alloc_idx, retire_valid, retire_entry,
             flush_out, flush_pc, rob_empty, rob_count
   );
endinterface

// File: rtl/rob_payload_ram.sv
// Reorder-buffer payload storage: one write port per dispatch lane, one async read port per retire lane.
module rob_payload_ram
   import core_pkg::*;
#(
   parameter int ENTRIES  = 32,
   parameter int WR_PORTS = 2,
   parameter int RD_PORTS = 2,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic                           clk,
   input  logic [WR_PORTS-1:0]            we,
   input  logic [WR_PORTS-1:0][IDX_W-1:0] waddr,
   input  ROB_Entry [WR_PORTS-1:0]        wdata,
   input  logic [RD_PORTS-1:0][IDX_W-1:0] raddr,
   output ROB_Entry [RD_PORTS-1:0]        rdata
);
   ROB_Entry mem [ENTRIES];

   // Lane writes always target distinct indices, so port order does not matter.
   always_ff @(posedge clk) begin
      for (int i = 0; i < WR_PORTS; i++) begin
         if (we[i]) begin
            mem[waddr[i]] <= wdata[i];
         end
      end
   end

   // Read ports follow the retire pointers combinationally.
   always_comb begin
      for (int r = 0; r < RD_PORTS; r++) begin
         rdata[r] = mem[raddr[r]];
      end
   end
endmodule

// File: rtl/rob_core.sv
// Reorder buffer: in-order allocate, out-of-order completion, in-order retire with exception flush.
module rob_core
   import core_pkg::*;
#(
   parameter int ROB_ENTRIES  = core_pkg::ROB_ENTRIES,
   parameter int DISP_WIDTH   = 2,
   parameter int NUM_FUS      = 4,
   parameter int RETIRE_WIDTH = 2
) (
   input  logic clk,
   input  logic rst,
   rob_if.slave bus
);
   localparam int             IDX_W       = $clog2(ROB_ENTRIES);
   localparam logic [IDX_W:0] ALLOC_LIMIT = (IDX_W+1)'(ROB_ENTRIES - DISP_WIDTH);

   logic [IDX_W-1:0]                     head_r, tail_r;
   logic [IDX_W:0]                       count_r;
   logic [ROB_ENTRIES-1:0]               occ_r, done_r, exc_r;
   logic [ROB_ENTRIES-1:0]               occ_nx, done_nx, exc_nx;
   logic                                 alloc_ready_s, flush_s;
   logic [DISP_WIDTH-1:0]                alloc_we_s;
   logic [DISP_WIDTH-1:0][IDX_W-1:0]     alloc_idx_s;
   logic [IDX_W:0]                       alloc_cnt_s, retire_cnt_s;
   logic [RETIRE_WIDTH-1:0]              retire_valid_s;
   logic [RETIRE_WIDTH-1:0][IDX_W-1:0]   rd_idx_s;
   ROB_Entry [RETIRE_WIDTH-1:0]          rd_entry_s;

   // Lane i takes tail plus the number of valid lanes below it; no credit for same-cycle retires.
   always_comb begin
      logic [IDX_W:0] n;
      n             = '0;
      alloc_ready_s = (count_r <= ALLOC_LIMIT);
      for (int i = 0; i < DISP_WIDTH; i++) begin
         alloc_idx_s[i] = tail_r + n[IDX_W-1:0];
         alloc_we_s[i]  = bus.alloc_valid[i] & alloc_ready_s;
         n              = n + {{IDX_W{1'b0}}, bus.alloc_valid[i]};
      end
      alloc_cnt_s = alloc_ready_s ? n : '0;
   end

   // Retire the longest done, non-excepting prefix; an excepting head raises flush instead.
   always_comb begin
      logic run;
      run          = 1'b1;
      retire_cnt_s = '0;
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
         rd_idx_s[k]       = head_r + IDX_W'(k);
         run               = run & occ_r[rd_idx_s[k]] & done_r[rd_idx_s[k]] & ~exc_r[rd_idx_s[k]];
         retire_valid_s[k] = run;
         retire_cnt_s      = retire_cnt_s + {{IDX_W{1'b0}}, run};
      end
      flush_s = occ_r[head_r] & done_r[head_r] & exc_r[head_r];
   end

   // Status next-state; ports to the same index OR together, and unoccupied targets are ignored.
   always_comb begin
      occ_nx  = occ_r;
      done_nx = done_r;
      exc_nx  = exc_r;
      for (int w = 0; w < NUM_FUS; w++) begin
         done_nx[bus.wb_idx[w]] = done_nx[bus.wb_idx[w]] | (bus.wb_valid[w] & occ_r[bus.wb_idx[w]]);
         exc_nx[bus.wb_idx[w]]  = exc_nx[bus.wb_idx[w]]
                                | (bus.wb_valid[w] & occ_r[bus.wb_idx[w]] & bus.wb_exc[w]);
      end
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
         occ_nx[rd_idx_s[k]] = occ_nx[rd_idx_s[k]] & ~retire_valid_s[k];
      end
      for (int i = 0; i < DISP_WIDTH; i++) begin
         occ_nx[alloc_idx_s[i]]  = occ_nx[alloc_idx_s[i]] | alloc_we_s[i];
         done_nx[alloc_idx_s[i]] = done_nx[alloc_idx_s[i]] & ~alloc_we_s[i];
         exc_nx[alloc_idx_s[i]]  = exc_nx[alloc_idx_s[i]] & ~alloc_we_s[i];
      end
   end

   // Pointer, occupancy and status registers; a flush empties the buffer and drops its allocations.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
         occ_r   <= '0;
         done_r  <= '0;
         exc_r   <= '0;
      end else if (flush_s) begin
         tail_r  <= head_r;
         count_r <= '0;
         occ_r   <= '0;
         done_r  <= '0;
         exc_r   <= '0;
      end else begin
         head_r  <= head_r + retire_cnt_s[IDX_W-1:0];
         tail_r  <= tail_r + alloc_cnt_s[IDX_W-1:0];
         count_r <= count_r + alloc_cnt_s - retire_cnt_s;
         occ_r   <= occ_nx;
         done_r  <= done_nx;
         exc_r   <= exc_nx;
      end
   end

   rob_payload_ram #(
      .ENTRIES  (ROB_ENTRIES),
      .WR_PORTS (DISP_WIDTH),
      .RD_PORTS (RETIRE_WIDTH)
   ) u_payload (
      .clk   (clk),
      .we    (alloc_we_s),
      .waddr (alloc_idx_s),
      .wdata (bus.alloc_entry),
      .raddr (rd_idx_s),
      .rdata (rd_entry_s)
   );

   assign bus.alloc_ready  = alloc_ready_s;
   assign bus.alloc_idx    = alloc_idx_s;
   assign bus.retire_valid = retire_valid_s;
   assign bus.retire_entry = rd_entry_s;
   assign bus.flush_out    = flush_s;
   assign bus.flush_pc     = flush_s ? rd_entry_s[0].pc : 32'd0;
   assign bus.rob_empty    = (count_r == '0);
   assign bus.rob_count    = count_r;
endmodule
